req_encoder_rr: RTL and testbench
=================================

Name: req_encoder_rr

Overview:
- Registered 16-to-4 round-robin request encoder. It is the inverse of the router's 4-to-16 one-hot select decoder.
- Collapses a 16-bit request vector into one granted 4-bit index plus a matching one-hot grant.
- Uses a valid/ready output handshake, so the downstream decoder/FIFO-select path can stall it.
- Sits between the per-port request sources and the select decoder in the router datapath.

Parameters:
- N, 16, number of request lines; must be a power of 2 and at least 2.
- W, 4, index width; always log2(N); derived, never overridden independently.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  N  request vector; any number of bits may be set.
- out_ready  in  1  downstream accepts the current grant.
- out_valid  out  1  grant register holds a valid grant.
- out_idx  out  W  binary index of the granted request.
- out_onehot  out  N  one-hot equal to 1<<out_idx when out_valid is 1; all-zero otherwise.
- busy  out  1  high when req is nonzero or out_valid is 1.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_idx=0, out_onehot=0, ptr=0, lock state cleared. busy follows its combinational definition.
- fire = out_valid & out_ready.
- load = ~out_valid | out_ready.
- Stall (out_valid=1, out_ready=0): out_valid, out_idx, out_onehot and ptr hold. req is ignored.
- On a load cycle with req!=0:
  - Pick k = the first set bit of req searching from ptr upward, wrapping N-1 to 0.
  - Next edge: out_valid=1, out_idx=k, out_onehot=1<<k.
  - Next edge: ptr = (k+1) mod N; k=N-1 wraps ptr to 0.
- On a load cycle with req==0: out_valid=0 and out_onehot=0 next edge; out_idx and ptr hold.
- Latency: req sampled on load cycle C appears on outputs at C+1.
- Back-to-back: with out_ready tied high, a new grant is issued every cycle.
- Fairness: each continuously asserted request is granted within N grants.
- req changing during a stall has no effect until the first load cycle after the stall.
- A single request bit set at ptr is granted immediately.
- Reset asserted mid-stall drops the grant at once. No handshake completes during reset.

Optional Feature:
- Macro: ENC_HOLD_EN (packet lock).
- With ENC_HOLD_EN:
  - After index k is granted, the block enters LOCKED with lock_idx=k.
  - While LOCKED, every load cycle with req[lock_idx]=1 re-grants lock_idx, and ptr does not advance.
  - At a load cycle with req[lock_idx]=0, the block returns to IDLE and performs a normal round-robin pick in that same cycle, searching from lock_idx+1.
  - States: IDLE, LOCKED. Reset enters IDLE.
- Without ENC_HOLD_EN: no lock state; every grant advances ptr as specified above.

Decomposition:
- Shared router package/header holds:
  - N and W constants.
  - The index-to-one-hot function shared with the select decoder.
  - IDLE/LOCKED state encodings.
- One natural sub-module: rr_pick.
  - Combinational: takes req and ptr, returns a found flag and index k.
  - Implemented as a masked plus unmasked priority search.
- req_encoder_rr holds the registers, handshake and lock FSM.

Test Plan:
- Reset: hold resetn=0 with req=16'hFFFF, then release. Cycle 0 after release shows out_valid=0 and out_onehot=0. The next edge grants idx 0.
- Round-robin, out_ready=1, req=16'h8421: grants 0,5,10,15,0 on consecutive cycles; out_onehot matches each index.
- Wrap, ptr=15, req=16'h0003: grants idx 0, then 1; ptr returns to 1 then 2.
- Stall: grant idx 3 with out_ready=0 for 4 cycles while req changes to 16'h0100. Outputs hold idx 3. On out_ready=1, the next grant is idx 8.
- Empty: single pulse req=16'h0040 then req=0 with out_ready=1. Grant idx 6 for one cycle, then out_valid=0, out_onehot=0, busy=0.
- ENC_HOLD_EN, req=16'h0011 with bit 0 held 3 cycles, out_ready=1: idx 0 is granted 3 times. Once bit 0 drops, idx 4 is granted next.

Source files
------------

// File: rtl/req_encoder_rr_pkg.sv
// req_encoder_rr_pkg: shared router constants, index-to-one-hot helper and lock states
package req_encoder_rr_pkg;
  localparam int ENC_N = 16;
  localparam int ENC_W = $clog2(ENC_N);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_t;
  function automatic logic [ENC_N-1:0] idx2onehot(input logic [ENC_W-1:0] i);
    return ENC_N'(1) << i;
  endfunction
endpackage

// File: rtl/req_encoder_rr_rr_pick.sv
// rr_pick: round-robin search for the first set request at or above ptr, wrapping to bit 0
module rr_pick #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] k
);
  logic [N-1:0] masked;
  logic [W-1:0] km, ku;
  assign masked = req & ~((N'(1) << ptr) - N'(1));
  assign found = |req;
  always_comb begin
    km = '0;
    ku = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) km = W'(i);
      if (req[i]) ku = W'(i);
    end
  end
  // Nothing at or above ptr means the search wrapped: take the lowest request overall
  assign k = |masked ? km : ku;
endmodule

// File: rtl/req_encoder_rr.sv
// req_encoder_rr: registered N-to-log2(N) round-robin request encoder with valid/ready output.
// Optional packet lock (re-grant while the locked request stays high) under ENC_HOLD_EN.
module req_encoder_rr
  import req_encoder_rr_pkg::*;
#(
  parameter int N = ENC_N
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [N-1:0]         req,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 busy
);
  localparam int W = $clog2(N);
  logic [W-1:0] ptr, k, gnt_idx;
  logic found, hold, gnt, load;
  assign load = ~out_valid | out_ready;
  assign busy = |req | out_valid;
  rr_pick #(.N(N)) u_pick (.req(req), .ptr(ptr), .found(found), .k(k));
`ifdef ENC_HOLD_EN
  lock_state_t state, state_n;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (load) state_n = gnt ? LOCKED : IDLE;
  end
  // While locked, out_idx is the lock index; ptr already sits at lock_idx+1
  assign hold = state == LOCKED && req[out_idx];
`else
  assign hold = 1'b0;
`endif
  assign gnt = hold | found;
  assign gnt_idx = hold ? out_idx : k;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= '0;
    end else if (load) begin
      out_valid  <= gnt;
      out_onehot <= gnt ? N'(1) << gnt_idx : '0;
      if (gnt) out_idx <= gnt_idx;
      if (found && !hold) ptr <= k + 1'b1;
    end
endmodule

// File: tb/tb_req_encoder_rr.sv
// tb_req_encoder_rr: scoreboard bench for req_encoder_rr; honours ENC_HOLD_EN when defined
module tb_req_encoder_rr;
  typedef struct {logic v; logic [3:0] idx; logic [15:0] oh;} exp_t;
  logic clock = 0, resetn = 0, out_ready = 0, out_valid, busy;
  logic [15:0] req = 0, out_onehot;
  logic [3:0] out_idx;
  int checks = 0, errors = 0;
  exp_t q[$];
  logic m_valid = 0, m_locked = 0;
  logic [3:0] m_idx = 0, m_ptr = 0;
`ifdef ENC_HOLD_EN
  localparam bit HOLD = 1;
`else
  localparam bit HOLD = 0;
`endif

  always #5 clock = ~clock;

  req_encoder_rr dut (
    .clock(clock), .resetn(resetn), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .out_onehot(out_onehot), .busy(busy)
  );

  task automatic model_reset;
    m_valid = 0; m_idx = 0; m_ptr = 0; m_locked = 0;
  endtask

  task automatic model_step(input logic [15:0] r, input logic rdy);
    exp_t e;
    bit f;
    int kk;
    if (!m_valid || rdy) begin
      if (HOLD && m_locked && r[m_idx]) m_valid = 1;
      else begin
        f = 0; kk = 0;
        for (int j = 0; j < 16; j++)
          if (!f && r[(m_ptr + j) % 16]) begin f = 1; kk = (m_ptr + j) % 16; end
        m_valid = f;
        m_locked = f && HOLD;
        if (f) begin m_idx = 4'(kk); m_ptr = 4'(kk + 1); end
      end
    end
    e.v = m_valid; e.idx = m_idx; e.oh = m_valid ? 16'(1) << m_idx : 16'h0;
    q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] r, input logic rdy);
    req = r; out_ready = rdy;
    model_step(r, rdy);
    @(posedge clock); #1;
  endtask

  task automatic do_reset;
    resetn = 0; #1;
    model_reset();
    q.delete();
    resetn = 1;
  endtask

  task automatic test_reset;
    exp_t e;
    resetn = 0; req = 16'hFFFF; out_ready = 1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 0 || out_onehot !== 0 || out_idx !== 0 || busy !== 1) begin
      errors++; $display("FAIL reset_hold: got v=%b idx=%0d oh=%h busy=%b, want 0 0 0000 1", out_valid, out_idx, out_onehot, busy);
    end
    resetn = 1; #1;
    checks++;
    if (out_valid !== 0 || out_onehot !== 0) begin
      errors++; $display("FAIL reset_release: got v=%b oh=%h, want 0 0000", out_valid, out_onehot);
    end
    drive(16'hFFFF, 1);
    e = q.pop_front();
    checks++;
    if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || out_idx !== 4'd0 || out_onehot !== 16'h0001) begin
      errors++; $display("FAIL reset_first_grant: got v=%b idx=%0d oh=%h, want v=1 idx=0 oh=0001", out_valid, out_idx, out_onehot);
    end
  endtask

  task automatic test_round_robin;
    exp_t e;
    int want[5];
    want = '{0, 5, 10, 15, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(16'h8421, 1);
      e = q.pop_front();
      checks++;
      if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || out_idx !== 4'(want[i]) || out_valid !== 1) begin
        errors++; $display("FAIL rr[%0d]: got v=%b idx=%0d oh=%h, want v=1 idx=%0d oh=%h", i, out_valid, out_idx, out_onehot, want[i], e.oh);
      end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    int want[3];
    logic [15:0] r[3];
    want = '{14, 0, 1};
    r = '{16'h4000, 16'h0003, 16'h0003};
    for (int i = 0; i < 3; i++) begin
      drive(r[i], 1);
      e = q.pop_front();
      checks++;
      if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || out_idx !== 4'(want[i])) begin
        errors++; $display("FAIL wrap[%0d]: got v=%b idx=%0d oh=%h, want v=1 idx=%0d oh=%h", i, out_valid, out_idx, out_onehot, want[i], e.oh);
      end
    end
  endtask

  task automatic test_stall;
    exp_t e;
    drive(16'h0008, 1);
    for (int i = 0; i < 6; i++) begin
      if (i >= 1) drive(16'h0100, i == 5);
      if (i == 0) e = q.pop_front(); else e = q.pop_front();
      checks++;
      if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || out_idx !== (i == 5 ? 4'd8 : 4'd3)) begin
        errors++; $display("FAIL stall[%0d]: got v=%b idx=%0d oh=%h, want v=1 idx=%0d oh=%h", i, out_valid, out_idx, out_onehot, e.idx, e.oh);
      end
    end
    drive(16'h0001, 0);
    e = q.pop_front();
    checks++;
    if (out_valid !== e.v || out_idx !== 4'd8) begin
      errors++; $display("FAIL stall_pre_reset: got v=%b idx=%0d, want v=1 idx=8", out_valid, out_idx);
    end
    resetn = 0; #1;
    checks++;
    if (out_valid !== 0 || out_onehot !== 0 || out_idx !== 0) begin
      errors++; $display("FAIL stall_reset: got v=%b idx=%0d oh=%h, want 0 0 0000", out_valid, out_idx, out_onehot);
    end
    model_reset();
    resetn = 1;
  endtask

  task automatic test_empty;
    exp_t e;
    drive(16'h0040, 1);
    e = q.pop_front();
    checks++;
    if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || out_onehot !== 16'h0040) begin
      errors++; $display("FAIL empty_pulse: got v=%b idx=%0d oh=%h, want v=1 idx=6 oh=0040", out_valid, out_idx, out_onehot);
    end
    drive(16'h0000, 1);
    e = q.pop_front();
    checks++;
    if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || out_valid !== 0 || out_onehot !== 0 || busy !== 0) begin
      errors++; $display("FAIL empty_idle: got v=%b idx=%0d oh=%h busy=%b, want v=0 idx=6 oh=0000 busy=0", out_valid, out_idx, out_onehot, busy);
    end
  endtask

  task automatic test_hold;
    exp_t e;
    int want[4];
`ifdef ENC_HOLD_EN
    want = '{0, 0, 0, 4};
`else
    want = '{0, 4, 0, 4};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(i < 3 ? 16'h0011 : 16'h0010, 1);
      e = q.pop_front();
      checks++;
      if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || out_idx !== 4'(want[i])) begin
        errors++; $display("FAIL hold[%0d]: got v=%b idx=%0d oh=%h, want v=1 idx=%0d oh=%h", i, out_valid, out_idx, out_onehot, want[i], e.oh);
      end
    end
  endtask

  task automatic test_random;
    exp_t e;
    logic [15:0] r;
    for (int i = 0; i < 80; i++) begin
      r = 16'($urandom) & 16'($urandom);
      if (i % 7 == 3) r = 16'h0;
      drive(r, $urandom_range(0, 3) != 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== e.v || out_idx !== e.idx || out_onehot !== e.oh || busy !== ((r != 0) | e.v)) begin
        errors++; $display("FAIL rand[%0d]: got v=%b idx=%0d oh=%h busy=%b, want v=%b idx=%0d oh=%h", i, out_valid, out_idx, out_onehot, busy, e.v, e.idx, e.oh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_empty();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
